// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS core datapath blocks.
//   addr_t     : 32-bit byte address
//   RESET_VEC  : PC after reset (ROM word 0, kernel mode)
//   IRQ_VEC    : interrupt handler entry (ROM word 1)
//   EXC_VEC    : illegal-instruction handler entry (ROM word 2)
//   KERNEL_BIT : PC bit that marks kernel/supervisor mode
package mips_pkg;

    typedef logic [31:0] addr_t;

    localparam addr_t       RESET_VEC  = 32'h8000_0000;
    localparam addr_t       IRQ_VEC    = 32'h8000_0004;
    localparam addr_t       EXC_VEC    = 32'h8000_0008;
    localparam int unsigned KERNEL_BIT = 31;

endpackage

// File: rtl/irq_sync.sv
// irq_sync: brings the asynchronous interrupt level into the clock domain,
// detects its rising edge and latches it as a pending request.
//   clk     : core clock
//   reset   : asynchronous active-high reset, clears chain and pending
//   irq_in  : external interrupt request (asynchronous level)
//   clr     : the pending request is being taken at this edge
//   pending : an interrupt is waiting to be taken
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_prev;
    logic                   sync_rise;

    assign sync_rise = sync_chain[SYNC_STAGES-1] & ~sync_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            sync_prev  <= 1'b0;
            pending    <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], irq_in};
            sync_prev  <= sync_chain[SYNC_STAGES-1];
            // A fresh edge arriving on the take edge must not be lost.
            if (sync_rise)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage of the single-cycle MIPS core.
//   clk, reset    : core clock, asynchronous active-high reset
//   stall         : hold the PC, take no redirect
//   irq_in        : external interrupt request (asynchronous level)
//   illegal_op    : current instruction is unimplemented
//   jr_en/jr_addr : jr/jalr with its rs value
//   jump_en/jump_target : j/jal with instr[25:0]
//   branch_taken/branch_imm : taken branch with instr[15:0]
//   pc            : current PC (instruction ROM address)
//   pc_plus4      : pc+4 within the current mode, jal link value
//   epc_we/epc    : write return address into $26 at this edge
//   irq_ack       : interrupt taken this cycle
//   kernel_mode   : pc[31]
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter addr_t       RESET_VEC   = mips_pkg::RESET_VEC,
    parameter addr_t       IRQ_VEC     = mips_pkg::IRQ_VEC,
    parameter addr_t       EXC_VEC     = mips_pkg::EXC_VEC,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        irq_in,
    input  logic        illegal_op,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    input  logic        jump_en,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        epc_we,
    output logic [31:0] epc,
    output logic        irq_ack,
    output logic        kernel_mode
);

    logic  irq_pending;
    logic  take_exc;
    logic  take_irq;
    addr_t br_offset;
    addr_t br_sum;
    addr_t br_target;
    addr_t jmp_target;
    addr_t pc_next;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .clr     (take_irq),
        .pending (irq_pending)
    );

    assign kernel_mode = pc[KERNEL_BIT];

    // Increment and branch arithmetic never carry into the mode bit.
    assign pc_plus4   = {pc[31], pc[30:0] + 31'd4};
    assign br_offset  = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign br_sum     = pc_plus4 + br_offset;
    assign br_target  = {pc[31], br_sum[30:0]};
    assign jmp_target = {pc[31], pc_plus4[30:28], jump_target, 2'b00};

    // Reset gating keeps the $26 write and ack quiet while reset is held.
    assign take_exc = illegal_op & ~stall & ~reset;
    assign take_irq = irq_pending & ~pc[KERNEL_BIT] & ~stall & ~illegal_op & ~reset;

    always_comb begin
        epc_we  = 1'b0;
        epc     = '0;
        irq_ack = 1'b0;
        pc_next = pc_plus4;
        if (stall) begin
            pc_next = pc;
        end else if (take_exc) begin
            pc_next = EXC_VEC;
            epc_we  = 1'b1;
            epc     = pc_plus4;
        end else if (take_irq) begin
            pc_next = IRQ_VEC;
            epc_we  = 1'b1;
            epc     = pc;
            irq_ack = 1'b1;
        end else if (jr_en) begin
            pc_next = jr_addr;
        end else if (jump_en) begin
            pc_next = jmp_target;
        end else if (branch_taken) begin
            pc_next = br_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_VEC;
        else
            pc <= pc_next;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the PC stage.
module tb_pc_fetch_unit;
    import mips_pkg::*;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset, stall, irq_in, illegal_op, jr_en, jump_en, branch_taken;
    logic [31:0] jr_addr;
    logic [25:0] jump_target;
    logic [15:0] branch_imm;
    logic [31:0] pc, pc_plus4, epc;
    logic        epc_we, irq_ack, kernel_mode;

    int checks = 0;
    int failures = 0;

    // Model state: architectural PC, pending flag, and the irq_in value
    // seen at every clock edge since the last reset.
    logic [31:0] m_pc;
    bit          m_pend;
    bit          hist[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_VEC   (RESET_VEC),
        .IRQ_VEC     (IRQ_VEC),
        .EXC_VEC     (EXC_VEC),
        .SYNC_STAGES (S)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .irq_in       (irq_in),
        .illegal_op   (illegal_op),
        .jr_en        (jr_en),
        .jr_addr      (jr_addr),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc_we       (epc_we),
        .epc          (epc),
        .irq_ack      (irq_ack),
        .kernel_mode  (kernel_mode)
    );

    // irq_in as sampled on edge k (1-based since reset); 0 before reset.
    function automatic bit s_at(int k);
        if (k < 1 || k > hist.size()) return 1'b0;
        return hist[k-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_VEC;
        m_pend = 1'b0;
        hist.delete();
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cycle();
        logic [31:0] cur, e_p4, e_next, e_epc, off;
        bit          t_exc, t_irq, set;
        int          n;
        #1;
        cur   = reset ? RESET_VEC : m_pc;
        e_p4  = (cur & 32'h8000_0000) | ((cur + 32'd4) & 32'h7FFF_FFFF);
        t_exc = !reset && illegal_op && !stall;
        t_irq = !reset && m_pend && !cur[31] && !stall && !illegal_op;
        e_epc = t_exc ? e_p4 : (t_irq ? cur : 32'd0);
        chk("pc", pc, cur);
        chk("pc_plus4", pc_plus4, e_p4);
        chk("kernel_mode", {31'd0, kernel_mode}, {31'd0, cur[31]});
        chk("epc_we", {31'd0, epc_we}, {31'd0, (t_exc || t_irq)});
        chk("epc", epc, e_epc);
        chk("irq_ack", {31'd0, irq_ack}, {31'd0, t_irq});
        off = {{16{branch_imm[15]}}, branch_imm} * 32'd4;
        if (stall)             e_next = cur;
        else if (t_exc)        e_next = EXC_VEC;
        else if (t_irq)        e_next = IRQ_VEC;
        else if (jr_en)        e_next = jr_addr;
        else if (jump_en)      e_next = (cur & 32'h8000_0000) | (e_p4 & 32'h7000_0000) | ({6'd0, jump_target} * 32'd4);
        else if (branch_taken) e_next = (cur & 32'h8000_0000) | ((e_p4 + off) & 32'h7FFF_FFFF);
        else                   e_next = e_p4;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            hist.push_back(irq_in);
            n   = hist.size();
            set = s_at(n - S) && !s_at(n - S - 1);
            m_pc = e_next;
            if (set)        m_pend = 1'b1;
            else if (t_irq) m_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; illegal_op = 0; jr_en = 0; jump_en = 0; branch_taken = 0;
        jr_addr = '0; jump_target = '0; branch_imm = '0;
    endtask

    task automatic do_jr(input logic [31:0] a);
        idle();
        jr_en = 1; jr_addr = a;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        irq_in = 0;
        reset  = 1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_pc_plus4", pc_plus4, 32'h8000_0004);
        illegal_op = 1;
        cycle();
        illegal_op = 0;
        cycle();
        reset = 0;

        // Sequential fetch out of reset.
        chk("seq0", pc, 32'h8000_0000);
        cycle();
        chk("seq1", pc, 32'h8000_0004);
        cycle();
        chk("seq2", pc, 32'h8000_0008);
        chk("seq_kernel", {31'd0, kernel_mode}, 32'd1);

        // Backward branch in user mode.
        do_jr(32'h0000_0040);
        chk("br_start", pc, 32'h0000_0040);
        branch_taken = 1; branch_imm = 16'hFFFD;
        cycle();
        idle();
        chk("br_target", pc, 32'h0000_0038);

        // Jump in kernel mode, then jr back to user mode.
        do_jr(32'h8000_0100);
        jump_en = 1; jump_target = 26'h15;
        cycle();
        idle();
        chk("jump_target", pc, 32'h8000_0054);
        do_jr(32'h0000_0010);
        chk("jr_pc", pc, 32'h0000_0010);
        chk("jr_user", {31'd0, kernel_mode}, 32'd0);

        // Interrupt: irq_in rise sampled on edge 1, pending after edge 3,
        // taken while the PC sits at 0x20.
        do_jr(32'h0000_0014);
        irq_in = 1;
        cycle(); cycle(); cycle();
        #1;
        chk("irq_ack_pc20", {31'd0, irq_ack}, 32'd1);
        chk("irq_epc", epc, 32'h0000_0020);
        chk("irq_epc_we", {31'd0, epc_we}, 32'd1);
        cycle();
        chk("irq_vec", pc, 32'h8000_0004);

        // Second interrupt arrives in kernel mode and must wait.
        irq_in = 0;
        cycle(); cycle();
        irq_in = 1;
        cycle(); cycle(); cycle(); cycle();
        chk("irq_masked", {31'd0, irq_ack}, 32'd0);

        // Exception beats the pending interrupt; interrupt follows later.
        do_jr(32'h0000_0030);
        illegal_op = 1;
        #1;
        chk("exc_epc", epc, 32'h0000_0034);
        chk("exc_no_ack", {31'd0, irq_ack}, 32'd0);
        cycle();
        idle();
        chk("exc_vec", pc, 32'h8000_0008);
        do_jr(32'h0000_0020);
        #1;
        chk("irq_after_exc", {31'd0, irq_ack}, 32'd1);
        chk("irq_after_exc_epc", epc, 32'h0000_0020);
        cycle();

        // Stall covers the cycle the interrupt becomes pending.
        irq_in = 0;
        do_jr(32'h0000_0100);
        cycle(); cycle();
        irq_in = 1;
        cycle(); cycle();
        stall = 1;
        cycle(); cycle(); cycle();
        chk("stall_pc", pc, 32'h0000_0110);
        stall = 0;
        #1;
        chk("stall_release_ack", {31'd0, irq_ack}, 32'd1);
        chk("stall_release_epc", epc, 32'h0000_0110);
        cycle();
        chk("stall_irq_vec", pc, 32'h8000_0004);

        // Reset in the middle of a stall with an interrupt pending.
        irq_in = 0;
        do_jr(32'h0000_0200);
        cycle(); cycle();
        irq_in = 1;
        stall = 1;
        cycle(); cycle(); cycle();
        #2;
        reset = 1;
        irq_in = 0;
        #1;
        chk("async_rst_pc", pc, 32'h8000_0000);
        model_reset();
        cycle();
        reset = 0;
        stall = 0;
        do_jr(32'h0000_0300);
        cycle(); cycle(); cycle();
        chk("rst_cleared_pending", {31'd0, irq_ack}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            idle();
            stall        = ($urandom_range(0, 9) == 0);
            illegal_op   = ($urandom_range(0, 29) == 0);
            jr_en        = ($urandom_range(0, 7) == 0);
            jr_addr      = $urandom;
            jr_addr[31]  = ($urandom_range(0, 3) == 0);
            jump_en      = ($urandom_range(0, 9) == 0);
            jump_target  = 26'($urandom);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_imm   = 16'($urandom);
            if ($urandom_range(0, 5) == 0) irq_in = ~irq_in;
            reset = ($urandom_range(0, 399) == 0);
            cycle();
            reset = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
